// File: rtl/glitch_scheduler_pkg.sv
// Shared types and default widths for the clock-glitch scheduler.
package glitch_sched_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_REP_W = 8;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_GLITCH,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/glitch_scheduler_if.sv
// Host/trigger/glitch-mux signal bundle for glitch_scheduler.
interface glitch_scheduler_if
  import glitch_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned REP_W = DEF_REP_W
) ();

  logic             arm;
  logic             abort;
  logic             trigger;
  logic [CNT_W-1:0] cfg_offset;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic             glitch_en;
  logic             ready;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_idx;

  modport master (
    output arm, abort, trigger, cfg_offset, cfg_width, cfg_gap, cfg_repeat,
    input  glitch_en, ready, busy, done, pulse_idx
  );

  modport slave (
    input  arm, abort, trigger, cfg_offset, cfg_width, cfg_gap, cfg_repeat,
    output glitch_en, ready, busy, done, pulse_idx
  );

endinterface

// File: rtl/glitch_scheduler_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, synchronously reset to 0.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/glitch_scheduler.sv
// Clock-glitch sequencer: lock qualification, arm, trigger offset, N pulses with gaps.
// GLITCH_SCHED_TRIG_SYNC_EN: route trigger through a 2-flop synchronizer (+2 cycles latency).
module glitch_scheduler
  import glitch_sched_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned REP_W       = DEF_REP_W
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                pll_locked,
  glitch_scheduler_if.slave   bus
);

  localparam int unsigned     LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  state_t             state, state_next;
  logic [LOCK_W-1:0]  lock_cnt, lock_cnt_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [REP_W-1:0]   rep_cnt, rep_next;
  logic [REP_W-1:0]   idx, idx_next;
  logic [CNT_W-1:0]   off_q, wid_q, gap_q;
  logic [REP_W-1:0]   rep_q;
  logic               load_cfg;
  logic               lock_s, trig_s, trig_prev, trig_edge;
  logic               glitch_q, done_q, busy_s;
  logic [CNT_W-1:0]   wid_last, gap_last;
  logic [REP_W-1:0]   rep_last;

  sync2 u_lock_sync (.clk(clock_in), .reset_n(reset_n), .d(pll_locked), .q(lock_s));

`ifdef GLITCH_SCHED_TRIG_SYNC_EN
  sync2 u_trig_sync (.clk(clock_in), .reset_n(reset_n), .d(bus.trigger), .q(trig_s));
`else
  assign trig_s = bus.trigger;
`endif

  assign trig_edge = trig_s & ~trig_prev;
  assign busy_s    = state inside {S_ARMED, S_DELAY, S_GLITCH, S_GAP};
  // Zero-valued settings behave as 1; counters hold N-1 and count down to 0.
  assign wid_last  = (wid_q == '0) ? '0 : wid_q - CNT_W'(1);
  assign gap_last  = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
  assign rep_last  = (rep_q == '0) ? '0 : rep_q - REP_W'(1);

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    cnt_next      = cnt;
    rep_next      = rep_cnt;
    idx_next      = idx;
    load_cfg      = 1'b0;
    if (!lock_s) begin
      state_next    = S_WAIT_LOCK;
      lock_cnt_next = '0;
    end else if (bus.abort && busy_s) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (lock_cnt == LOCK_LAST) state_next = S_IDLE;
          else lock_cnt_next = lock_cnt + LOCK_W'(1);
        end
        S_IDLE: begin
          if (bus.arm) begin
            load_cfg   = 1'b1;
            state_next = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            idx_next = '0;
            rep_next = rep_last;
            if (off_q == '0) begin
              state_next = S_GLITCH;
              cnt_next   = wid_last;
            end else begin
              state_next = S_DELAY;
              cnt_next   = off_q - CNT_W'(1);
            end
          end
        end
        S_DELAY: begin
          if (cnt == '0) begin
            state_next = S_GLITCH;
            cnt_next   = wid_last;
          end else cnt_next = cnt - CNT_W'(1);
        end
        S_GLITCH: begin
          if (cnt != '0) cnt_next = cnt - CNT_W'(1);
          else if (rep_cnt == '0) state_next = S_DONE;
          else begin
            state_next = S_GAP;
            cnt_next   = gap_last;
            rep_next   = rep_cnt - REP_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state_next = S_GLITCH;
            cnt_next   = wid_last;
            idx_next   = idx + REP_W'(1);
          end else cnt_next = cnt - CNT_W'(1);
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state     <= S_WAIT_LOCK;
      lock_cnt  <= '0;
      cnt       <= '0;
      rep_cnt   <= '0;
      idx       <= '0;
      off_q     <= '0;
      wid_q     <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      trig_prev <= 1'b0;
      glitch_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      lock_cnt  <= lock_cnt_next;
      cnt       <= cnt_next;
      rep_cnt   <= rep_next;
      idx       <= idx_next;
      trig_prev <= trig_s;
      // Output lags GLITCH by one cycle but is cut off on the abort/lock-loss edge itself.
      glitch_q  <= (state == S_GLITCH) && lock_s && !bus.abort;
      done_q    <= (state == S_DONE) && lock_s;
      if (load_cfg) begin
        off_q <= bus.cfg_offset;
        wid_q <= bus.cfg_width;
        gap_q <= bus.cfg_gap;
        rep_q <= bus.cfg_repeat;
      end
    end
  end

  assign bus.glitch_en = glitch_q;
  assign bus.done      = done_q;
  assign bus.ready     = (state == S_IDLE);
  assign bus.busy      = busy_s;
  assign bus.pulse_idx = idx;

endmodule
